riscv_du_bpu: RTL



---
 rtl/riscv_du_bpu.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/riscv_du_bpu.sv
// riscv_du_bpu: breakpoint/watchpoint unit sitting beside the debug unit.
//
// Up to 8 address comparators, each with a don't-care mask, a fetch/load/store
// condition and a pass counter. Triggers set sticky hit flags and drive a halt
// request through a RUN/HALTING/HALTED/SKIP state machine. The SKIP cycle after
// resume stops a fetch breakpoint from re-hitting the PC it halted on.
//
// Optional build macro: RISCV_DU_BP_CHAIN_EN enables comparator chaining
// (BPCTRL[8]). Without it bit 8 reads 0 and every comparator is independent.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   reg_req/we/addr/wdata register access request (held until reg_ack)
//   reg_rdata, reg_ack    registered read data and one-cycle acknowledge
//   if_pc, if_valid       fetch-stage PC and qualifier
//   mem_adr/valid/we      data access address, completion strobe, store flag
//   du_stall              CPU held by the debugger
//   bp_halt_req           halt request to the debug controller
//   bp_hit                sticky per-comparator hit flags
module riscv_du_bpu #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BREAKPOINTS = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   reg_req,
    input  logic                   reg_we,
    input  logic [7:0]             reg_addr,
    input  logic [XLEN-1:0]        reg_wdata,
    output logic [XLEN-1:0]        reg_rdata,
    output logic                   reg_ack,
    input  logic [XLEN-1:0]        if_pc,
    input  logic                   if_valid,
    input  logic [XLEN-1:0]        mem_adr,
    input  logic                   mem_valid,
    input  logic                   mem_we,
    input  logic                   du_stall,
    output logic                   bp_halt_req,
    output logic [BREAKPOINTS-1:0] bp_hit
);

    typedef enum logic [1:0] {StRun, StHalting, StHalted, StSkip} state_e;

    localparam logic [7:0] AddrCtrl = 8'h00;
    localparam logic [7:0] AddrHit  = 8'h01;

    // Register state
    logic                   ctrl_en_q;
    logic [BREAKPOINTS-1:0] hit_q;
    logic [BREAKPOINTS-1:0] bpen_q;
    logic [1:0]             cc_q     [BREAKPOINTS];
    logic [XLEN-1:0]        data_q   [BREAKPOINTS];
    logic [XLEN-1:0]        mask_q   [BREAKPOINTS];
    logic [CNT_W-1:0]       reload_q [BREAKPOINTS];
    logic [CNT_W-1:0]       cnt_q    [BREAKPOINTS];
`ifdef RISCV_DU_BP_CHAIN_EN
    logic [BREAKPOINTS-1:0] chain_q;
    logic [BREAKPOINTS-1:0] armed_q;
`endif
    logic                   ack_q;
    logic [XLEN-1:0]        rdata_q;
    state_e                 state_q;
    logic                   halt_req_q;

    // Access decode and match logic
    logic                   acc;
    logic                   wr;
    logic                   hit_wr;
    logic [BREAKPOINTS-1:0] hit_clr;
    logic [BREAKPOINTS-1:0] bp_sel;
    logic [BREAKPOINTS-1:0] cnt_wr;
    logic [BREAKPOINTS-1:0] kind_ok;
    logic [BREAKPOINTS-1:0] adr_hit;
    logic [BREAKPOINTS-1:0] qual;
    logic [BREAKPOINTS-1:0] trig;
    logic [BREAKPOINTS-1:0] succ_chained;
    logic [BREAKPOINTS-1:0] halt_trig;
    logic [XLEN-1:0]        rdata_d;

    always_comb begin
        // The ack cycle never starts a new access.
        acc          = reg_req & ~ack_q;
        wr           = acc & reg_we;
        hit_wr       = wr & (reg_addr == AddrHit);
        hit_clr      = hit_wr ? reg_wdata[BREAKPOINTS-1:0] : '0;
        bp_sel       = '0;
        cnt_wr       = '0;
        kind_ok      = '0;
        adr_hit      = '0;
        qual         = '0;
        trig         = '0;
        succ_chained = '0;
        for (int unsigned n = 0; n < BREAKPOINTS; n++) begin
            bp_sel[n] = (reg_addr[7:2] == 6'(n + 4));
            cnt_wr[n] = wr & bp_sel[n] & (reg_addr[1:0] == 2'd3);
            case (cc_q[n])
                2'd0: begin
                    kind_ok[n] = if_valid;
                    adr_hit[n] = ((if_pc ^ data_q[n]) & ~mask_q[n]) == '0;
                end
                2'd1: begin
                    kind_ok[n] = mem_valid & ~mem_we;
                    adr_hit[n] = ((mem_adr ^ data_q[n]) & ~mask_q[n]) == '0;
                end
                2'd2: begin
                    kind_ok[n] = mem_valid & mem_we;
                    adr_hit[n] = ((mem_adr ^ data_q[n]) & ~mask_q[n]) == '0;
                end
                default: begin
                    kind_ok[n] = mem_valid;
                    adr_hit[n] = ((mem_adr ^ data_q[n]) & ~mask_q[n]) == '0;
                end
            endcase
            // A BPCNT write in the same cycle discards the match entirely.
            qual[n] = ctrl_en_q & bpen_q[n] & (state_q == StRun) & kind_ok[n] & adr_hit[n]
                      & ~cnt_wr[n];
`ifdef RISCV_DU_BP_CHAIN_EN
            if ((n != 0) && chain_q[n] && !armed_q[n]) begin
                qual[n] = 1'b0;
            end
            if (n != 0) begin
                succ_chained[n-1] = chain_q[n] & bpen_q[n];
            end
`endif
            trig[n] = qual[n] & (cnt_q[n] == '0);
        end
        // A comparator feeding an enabled chained successor only arms it.
        halt_trig = trig & ~succ_chained;
    end

    // Read mux; unmapped addresses and unimplemented comparators read 0.
    always_comb begin
        rdata_d = '0;
        if (reg_addr == AddrCtrl) begin
            rdata_d[0] = ctrl_en_q;
        end else if (reg_addr == AddrHit) begin
            rdata_d[BREAKPOINTS-1:0] = hit_q;
        end
        for (int unsigned n = 0; n < BREAKPOINTS; n++) begin
            if (bp_sel[n]) begin
                case (reg_addr[1:0])
                    2'd0: begin
                        rdata_d[0]   = 1'b1;
                        rdata_d[1]   = bpen_q[n];
                        rdata_d[5:4] = cc_q[n];
`ifdef RISCV_DU_BP_CHAIN_EN
                        rdata_d[8]   = chain_q[n];
`endif
                    end
                    2'd1:    rdata_d = data_q[n];
                    2'd2:    rdata_d = mask_q[n];
                    default: rdata_d[CNT_W-1:0] = cnt_q[n];
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_en_q <= 1'b0;
            hit_q     <= '0;
            bpen_q    <= '0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            for (int unsigned n = 0; n < BREAKPOINTS; n++) begin
                cc_q[n]     <= '0;
                data_q[n]   <= '0;
                mask_q[n]   <= '0;
                reload_q[n] <= '0;
                cnt_q[n]    <= '0;
            end
`ifdef RISCV_DU_BP_CHAIN_EN
            chain_q <= '0;
            armed_q <= '0;
`endif
        end else begin
            ack_q <= acc;
            if (acc) begin
                rdata_q <= rdata_d;
            end
            if (wr && (reg_addr == AddrCtrl)) begin
                ctrl_en_q <= reg_wdata[0];
            end
            // Hardware set wins over a simultaneous write-1-to-clear.
            hit_q <= (hit_q & ~hit_clr) | trig;
            for (int unsigned n = 0; n < BREAKPOINTS; n++) begin
                if (wr && bp_sel[n]) begin
                    case (reg_addr[1:0])
                        2'd0: begin
                            bpen_q[n] <= reg_wdata[1];
                            cc_q[n]   <= reg_wdata[5:4];
`ifdef RISCV_DU_BP_CHAIN_EN
                            chain_q[n] <= reg_wdata[8];
`endif
                        end
                        2'd1:    data_q[n] <= reg_wdata;
                        2'd2:    mask_q[n] <= reg_wdata;
                        default: ;
                    endcase
                end
                if (cnt_wr[n]) begin
                    reload_q[n] <= reg_wdata[CNT_W-1:0];
                    cnt_q[n]    <= reg_wdata[CNT_W-1:0];
                end else if (qual[n]) begin
                    cnt_q[n] <= trig[n] ? reload_q[n] : cnt_q[n] - 1'b1;
                end
            end
`ifdef RISCV_DU_BP_CHAIN_EN
            armed_q[0] <= 1'b0;
            for (int unsigned n = 1; n < BREAKPOINTS; n++) begin
                armed_q[n] <= (armed_q[n] & ~(trig[n] | hit_wr)) | trig[n-1];
            end
`endif
        end
    end

    // Halt-request state machine; bp_halt_req rises the cycle after HALTING is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StRun;
            halt_req_q <= 1'b0;
        end else begin
            case (state_q)
                StRun: begin
                    halt_req_q <= 1'b0;
                    if (|halt_trig) begin
                        state_q <= StHalting;
                    end
                end
                StHalting: begin
                    if (!ctrl_en_q) begin
                        state_q    <= StRun;
                        halt_req_q <= 1'b0;
                    end else if (du_stall) begin
                        state_q    <= StHalted;
                        halt_req_q <= 1'b0;
                    end else begin
                        halt_req_q <= 1'b1;
                    end
                end
                StHalted: begin
                    halt_req_q <= 1'b0;
                    if (!du_stall) begin
                        state_q <= StSkip;
                    end
                end
                default: begin
                    halt_req_q <= 1'b0;
                    state_q    <= StRun;
                end
            endcase
        end
    end

    assign reg_ack     = ack_q;
    assign reg_rdata   = rdata_q;
    assign bp_halt_req = halt_req_q;
    assign bp_hit      = hit_q;

endmodule
